// File: rtl/mp3_frame_sync.sv
// MPEG-1 Layer III frame synchroniser: finds and decodes frame headers, drops the CRC,
// and splits each frame body into a side-information stream and a main-data stream.
module mp3_frame_sync (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  axiid,
   input  logic        axiiv,
   output logic [7:0]  side_axiod,
   output logic        side_axiov,
   output logic [7:0]  main_axiod,
   output logic        main_axiov,
   output logic        hdr_valid,
   output logic [3:0]  bitrate_index,
   output logic [1:0]  sampling_freq,
   output logic        padding_bit,
   output logic [1:0]  mode,
   output logic [1:0]  mode_extension,
   output logic        protection_bit,
   output logic [10:0] frame_len,
   output logic        locked
);

   typedef enum logic [2:0] {
      HUNT, H1, H2, H3, CRC, SIDE, MAIN, NEXT
   } state_t;

   state_t      state, state_nxt;
   logic [10:0] cnt, cnt_nxt;
   logic        locked_nxt;

   // Header bits seen in H1/H2, held until byte 3 commits the whole header.
   logic        prot_s;
   logic [3:0]  br_s;
   logic [1:0]  fs_s;
   logic        pad_s;

   logic        ld_b1, ld_b2, ld_hdr, fwd_side, fwd_main;
   logic        b0_ok, b1_ok, b2_ok;
   logic [10:0] new_frame_len, new_side_len;
   logic [10:0] side_len, crc_len, main_len;

   // Frame bytes without padding: floor(144000 * kbps / fs) for every legal {fs, bitrate}.
   function automatic logic [10:0] frame_bytes(input logic [1:0] fs, input logic [3:0] br);
      case ({fs, br})
         6'h01: frame_bytes = 11'd104;
         6'h02: frame_bytes = 11'd130;
         6'h03: frame_bytes = 11'd156;
         6'h04: frame_bytes = 11'd182;
         6'h05: frame_bytes = 11'd208;
         6'h06: frame_bytes = 11'd261;
         6'h07: frame_bytes = 11'd313;
         6'h08: frame_bytes = 11'd365;
         6'h09: frame_bytes = 11'd417;
         6'h0A: frame_bytes = 11'd522;
         6'h0B: frame_bytes = 11'd626;
         6'h0C: frame_bytes = 11'd731;
         6'h0D: frame_bytes = 11'd835;
         6'h0E: frame_bytes = 11'd1044;
         6'h11: frame_bytes = 11'd96;
         6'h12: frame_bytes = 11'd120;
         6'h13: frame_bytes = 11'd144;
         6'h14: frame_bytes = 11'd168;
         6'h15: frame_bytes = 11'd192;
         6'h16: frame_bytes = 11'd240;
         6'h17: frame_bytes = 11'd288;
         6'h18: frame_bytes = 11'd336;
         6'h19: frame_bytes = 11'd384;
         6'h1A: frame_bytes = 11'd480;
         6'h1B: frame_bytes = 11'd576;
         6'h1C: frame_bytes = 11'd672;
         6'h1D: frame_bytes = 11'd768;
         6'h1E: frame_bytes = 11'd960;
         6'h21: frame_bytes = 11'd144;
         6'h22: frame_bytes = 11'd180;
         6'h23: frame_bytes = 11'd216;
         6'h24: frame_bytes = 11'd252;
         6'h25: frame_bytes = 11'd288;
         6'h26: frame_bytes = 11'd360;
         6'h27: frame_bytes = 11'd432;
         6'h28: frame_bytes = 11'd504;
         6'h29: frame_bytes = 11'd576;
         6'h2A: frame_bytes = 11'd720;
         6'h2B: frame_bytes = 11'd864;
         6'h2C: frame_bytes = 11'd1008;
         6'h2D: frame_bytes = 11'd1152;
         6'h2E: frame_bytes = 11'd1440;
         default: frame_bytes = 11'd0;
      endcase
   endfunction

   assign b0_ok = (axiid == 8'hFF);
   assign b1_ok = ((axiid & 8'hFE) == 8'hFA);
   assign b2_ok = (axiid[7:4] != 4'h0) && (axiid[7:4] != 4'hF) && (axiid[3:2] != 2'd3);

   // Lengths of the frame whose byte 3 is on the bus right now.
   assign new_frame_len = frame_bytes(fs_s, br_s) + {10'd0, pad_s};
   assign new_side_len  = (axiid[7:6] == 2'd3) ? 11'd17 : 11'd32;

   // Lengths of the frame currently being split, from the committed header fields.
   assign side_len = (mode == 2'd3) ? 11'd17 : 11'd32;
   assign crc_len  = protection_bit ? 11'd0 : 11'd2;
   assign main_len = frame_len - 11'd4 - crc_len - side_len;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_nxt  = state;
      cnt_nxt    = cnt;
      locked_nxt = locked;
      ld_b1      = 1'b0;
      ld_b2      = 1'b0;
      ld_hdr     = 1'b0;
      fwd_side   = 1'b0;
      fwd_main   = 1'b0;

      if (axiiv) begin
         case (state)
            HUNT: begin
               if (b0_ok) state_nxt = H1;
            end
            // locked is only set while checking a header at a frame boundary; there a bad
            // byte loses sync, otherwise a stray 0xFF may itself be the real byte 0.
            H1: begin
               if (b1_ok) begin
                  ld_b1     = 1'b1;
                  state_nxt = H2;
               end else if (locked) begin
                  locked_nxt = 1'b0;
                  state_nxt  = HUNT;
               end else begin
                  state_nxt = b0_ok ? H1 : HUNT;
               end
            end
            H2: begin
               if (b2_ok) begin
                  ld_b2     = 1'b1;
                  state_nxt = H3;
               end else if (locked) begin
                  locked_nxt = 1'b0;
                  state_nxt  = HUNT;
               end else begin
                  state_nxt = b0_ok ? H1 : HUNT;
               end
            end
            H3: begin
               ld_hdr     = 1'b1;
               locked_nxt = 1'b1;
               if (!prot_s) begin
                  state_nxt = CRC;
                  cnt_nxt   = 11'd1;
               end else begin
                  state_nxt = SIDE;
                  cnt_nxt   = new_side_len - 11'd1;
               end
            end
            CRC: begin
               if (cnt == 11'd0) begin
                  state_nxt = SIDE;
                  cnt_nxt   = side_len - 11'd1;
               end else begin
                  cnt_nxt = cnt - 11'd1;
               end
            end
            SIDE: begin
               fwd_side = 1'b1;
               if (cnt == 11'd0) begin
                  state_nxt = MAIN;
                  cnt_nxt   = main_len - 11'd1;
               end else begin
                  cnt_nxt = cnt - 11'd1;
               end
            end
            MAIN: begin
               fwd_main = 1'b1;
               if (cnt == 11'd0) begin
                  state_nxt = NEXT;
                  cnt_nxt   = 11'd0;
               end else begin
                  cnt_nxt = cnt - 11'd1;
               end
            end
            NEXT: begin
               if (b0_ok) begin
                  state_nxt = H1;
               end else begin
                  locked_nxt = 1'b0;
                  state_nxt  = HUNT;
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= HUNT;
         cnt    <= 11'd0;
         locked <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         locked <= locked_nxt;
      end
   end

   // NOTE: the header shadow registers are reset as well; they are a handful of flops,
   // and a defined value keeps a header decoded right after reset free of X.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prot_s <= 1'b0;
         br_s   <= 4'd0;
         fs_s   <= 2'd0;
         pad_s  <= 1'b0;
      end else begin
         if (ld_b1) prot_s <= axiid[0];
         if (ld_b2) begin
            br_s  <= axiid[7:4];
            fs_s  <= axiid[3:2];
            pad_s <= axiid[1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         side_axiod     <= 8'd0;
         side_axiov     <= 1'b0;
         main_axiod     <= 8'd0;
         main_axiov     <= 1'b0;
         hdr_valid      <= 1'b0;
         bitrate_index  <= 4'd0;
         sampling_freq  <= 2'd0;
         padding_bit    <= 1'b0;
         mode           <= 2'd0;
         mode_extension <= 2'd0;
         protection_bit <= 1'b0;
         frame_len      <= 11'd0;
      end else begin
         side_axiov <= fwd_side;
         main_axiov <= fwd_main;
         hdr_valid  <= ld_hdr;
         if (fwd_side) side_axiod <= axiid;
         if (fwd_main) main_axiod <= axiid;
         if (ld_hdr) begin
            bitrate_index  <= br_s;
            sampling_freq  <= fs_s;
            padding_bit    <= pad_s;
            mode           <= axiid[7:6];
            mode_extension <= axiid[5:4];
            protection_bit <= prot_s;
            frame_len      <= new_frame_len;
         end
      end
   end

endmodule

// File: tb/tb_mp3_frame_sync.sv
// Directed bench for mp3_frame_sync: a frame model feeds side/main/header scoreboards,
// and a monitor compares every DUT output against them on the falling clock edge.
module tb_mp3_frame_sync;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  axiid = 8'd0;
   logic        axiiv = 1'b0;
   logic [7:0]  side_axiod, main_axiod;
   logic        side_axiov, main_axiov, hdr_valid;
   logic [3:0]  bitrate_index;
   logic [1:0]  sampling_freq, mode, mode_extension;
   logic        padding_bit, protection_bit, locked;
   logic [10:0] frame_len;

   mp3_frame_sync dut (
      .clk            (clk),
      .rst            (rst),
      .axiid          (axiid),
      .axiiv          (axiiv),
      .side_axiod     (side_axiod),
      .side_axiov     (side_axiov),
      .main_axiod     (main_axiod),
      .main_axiov     (main_axiov),
      .hdr_valid      (hdr_valid),
      .bitrate_index  (bitrate_index),
      .sampling_freq  (sampling_freq),
      .padding_bit    (padding_bit),
      .mode           (mode),
      .mode_extension (mode_extension),
      .protection_bit (protection_bit),
      .frame_len      (frame_len),
      .locked         (locked)
   );

   always #5 clk = ~clk;

   typedef enum {K_DROP, K_SIDE, K_MAIN} kind_t;

   typedef struct packed {
      logic [3:0]  br;
      logic [1:0]  fs;
      logic        pad;
      logic [1:0]  md;
      logic [1:0]  mx;
      logic        prot;
      logic [10:0] flen;
   } hdr_t;

   localparam int KBPS  [15] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320};
   localparam int FS_HZ [3]  = '{44100, 48000, 32000};

   logic [7:0] q_side [$];
   logic [7:0] q_main [$];
   hdr_t       q_hdr  [$];

   int   vectors = 0;
   int   miscompares = 0;
   bit   gappy = 1'b0;
   logic axiiv_q = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pay(input int i, input int salt);
      return 8'((i * 37 + salt * 11) ^ (i >> 3));
   endfunction

   // One byte with axiiv high; in gappy mode random idle cycles (with junk data) precede it.
   task automatic put(input logic [7:0] b, input kind_t k);
      if (gappy) begin
         while ($urandom_range(1, 0) == 1) begin
            axiiv = 1'b0;
            axiid = 8'($urandom);
            @(negedge clk);
         end
      end
      axiid = b;
      axiiv = 1'b1;
      if (k == K_SIDE) q_side.push_back(b);
      else if (k == K_MAIN) q_main.push_back(b);
      @(negedge clk);
      axiiv = 1'b0;
   endtask

   // Sends FF h1 h2 h3, optional CRC, then npay body bytes (all of them when npay < 0).
   task automatic send_frame(input logic [7:0] h1, input logic [7:0] h2, input logic [7:0] h3,
                             input int salt, input int npay);
      hdr_t h;
      int   flen, crc, side, total;
      h.br   = h2[7:4];
      h.fs   = h2[3:2];
      h.pad  = h2[1];
      h.md   = h3[7:6];
      h.mx   = h3[5:4];
      h.prot = h1[0];
      flen   = 144000 * KBPS[h.br] / FS_HZ[h.fs] + int'(h.pad);
      h.flen = 11'(flen);
      q_hdr.push_back(h);
      crc  = h.prot ? 0 : 2;
      side = (h.md == 2'd3) ? 17 : 32;
      put(8'hFF, K_DROP);
      put(h1, K_DROP);
      put(h2, K_DROP);
      put(h3, K_DROP);
      for (int i = 0; i < crc; i++) put(8'hC5, K_DROP);
      total = flen - 4 - crc;
      if (npay >= 0 && npay < total) total = npay;
      for (int i = 0; i < total; i++) put(pay(i, salt), (i < side) ? K_SIDE : K_MAIN);
   endtask

   always @(posedge clk) axiiv_q <= axiiv;

   always @(negedge clk) begin
      if (!rst) begin
         logic [7:0] eb;
         hdr_t       eh;
         check("valid_overlap", 32'(side_axiov && main_axiov), 0);
         check("valid_on_idle", 32'((side_axiov || main_axiov) && !axiiv_q), 0);
         if (side_axiov) begin
            check("side_pending", 32'(q_side.size() != 0), 1);
            if (q_side.size() != 0) begin
               eb = q_side.pop_front();
               check("side_data", 32'(side_axiod), 32'(eb));
            end
         end
         if (main_axiov) begin
            check("main_pending", 32'(q_main.size() != 0), 1);
            if (q_main.size() != 0) begin
               eb = q_main.pop_front();
               check("main_data", 32'(main_axiod), 32'(eb));
            end
         end
         if (hdr_valid) begin
            check("hdr_pending", 32'(q_hdr.size() != 0), 1);
            if (q_hdr.size() != 0) begin
               eh = q_hdr.pop_front();
               check("bitrate_index", 32'(bitrate_index), 32'(eh.br));
               check("sampling_freq", 32'(sampling_freq), 32'(eh.fs));
               check("padding_bit", 32'(padding_bit), 32'(eh.pad));
               check("mode", 32'(mode), 32'(eh.md));
               check("mode_extension", 32'(mode_extension), 32'(eh.mx));
               check("protection_bit", 32'(protection_bit), 32'(eh.prot));
               check("frame_len_hdr", 32'(frame_len), 32'(eh.flen));
               check("locked_at_hdr", 32'(locked), 1);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_side_axiov"}, 32'(side_axiov), 0);
      check({tag, "_main_axiov"}, 32'(main_axiov), 0);
      check({tag, "_side_axiod"}, 32'(side_axiod), 0);
      check({tag, "_main_axiod"}, 32'(main_axiod), 0);
      check({tag, "_hdr_valid"}, 32'(hdr_valid), 0);
      check({tag, "_fields"}, 32'({bitrate_index, sampling_freq, padding_bit, mode,
                                    mode_extension, protection_bit}), 0);
      check({tag, "_frame_len"}, 32'(frame_len), 0);
      check({tag, "_locked"}, 32'(locked), 0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Stereo 128 kbps / 44.1 kHz, no CRC: 32 side + 381 main
      send_frame(8'hFB, 8'h90, 8'h00, 1, -1);
      check("stereo_frame_len", 32'(frame_len), 417);
      check("stereo_mode", 32'(mode), 0);
      check("stereo_locked", 32'(locked), 1);

      // Mono 128 kbps / 48 kHz with CRC, taken at the frame boundary
      send_frame(8'hFA, 8'h94, 8'hC0, 2, -1);
      check("mono_frame_len", 32'(frame_len), 384);
      check("mono_mode", 32'(mode), 3);
      check("mono_locked", 32'(locked), 1);

      // Garbage at the boundary loses sync; 00 FF FF FB 90 00 resyncs on the second FF
      put(8'h00, K_DROP);
      check("garbage_unlocked", 32'(locked), 0);
      put(8'hFF, K_DROP);
      send_frame(8'hFB, 8'h90, 8'h00, 3, -1);
      check("resync_frame_len", 32'(frame_len), 417);
      check("resync_locked", 32'(locked), 1);

      // Bad bitrate index at the boundary, then bad bitrate / bad fs while hunting
      put(8'hFF, K_DROP);
      put(8'hFB, K_DROP);
      put(8'hF0, K_DROP);
      check("bad_br_unlocked", 32'(locked), 0);
      put(8'hFF, K_DROP);
      put(8'hFB, K_DROP);
      put(8'hF0, K_DROP);
      put(8'h00, K_DROP);
      put(8'hFF, K_DROP);
      put(8'hFB, K_DROP);
      put(8'h9C, K_DROP);
      put(8'h00, K_DROP);
      check("bad_hdr_locked", 32'(locked), 0);
      check("bad_hdr_frame_len_held", 32'(frame_len), 417);
      check("bad_hdr_mode_held", 32'(mode), 0);

      // Two back-to-back 320 kbps / 32 kHz padded frames
      send_frame(8'hFB, 8'hEA, 8'h00, 4, -1);
      check("b2b1_frame_len", 32'(frame_len), 1441);
      check("b2b1_locked", 32'(locked), 1);
      send_frame(8'hFB, 8'hEA, 8'h00, 5, -1);
      check("b2b2_frame_len", 32'(frame_len), 1441);
      check("b2b2_locked", 32'(locked), 1);

      // Third frame with a corrupted byte 0: nothing of it may be forwarded
      put(8'hFE, K_DROP);
      check("corrupt_unlocked", 32'(locked), 0);
      put(8'hFB, K_DROP);
      put(8'hEA, K_DROP);
      put(8'h00, K_DROP);
      for (int i = 0; i < 1437; i++) put(pay(i, 6) & 8'h7F, K_DROP);
      check("corrupt_still_unlocked", 32'(locked), 0);
      check("corrupt_frame_len_held", 32'(frame_len), 1441);

      // Mono CRC frame again with ~50% idle cycles; same payload as the gap-free run
      gappy = 1'b1;
      send_frame(8'hFA, 8'h94, 8'hC0, 2, -1);
      gappy = 1'b0;
      check("gappy_frame_len", 32'(frame_len), 384);
      check("gappy_locked", 32'(locked), 1);

      // Reset in the middle of MAIN (32 side + 10 main bytes sent)
      send_frame(8'hFB, 8'h90, 8'h00, 7, 42);
      check("pre_reset_main_valid", 32'(main_axiov), 1);
      #2 rst = 1'b1;
      #1;
      check_all_zero("midreset");
      q_side.delete();
      q_main.delete();
      q_hdr.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Fresh header after reset
      send_frame(8'hFB, 8'h90, 8'h00, 8, -1);
      check("post_reset_frame_len", 32'(frame_len), 417);
      check("post_reset_locked", 32'(locked), 1);

      repeat (3) @(negedge clk);
      check("side_queue_drained", 32'(q_side.size()), 0);
      check("main_queue_drained", 32'(q_main.size()), 0);
      check("hdr_queue_drained", 32'(q_hdr.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
